// File: rtl/tac_pkg.sv
// Shared types and helpers for the toggle activity counter: the FSM state
// encoding and the bit width needed to hold a popcount of a WIDTH-bit vector.
package tac_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } tac_state_e;

    function automatic int pc_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/tac_popcount.sv
// Purely combinational population count of a WIDTH-bit vector.
module tac_popcount
    import tac_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]           vec,
    output logic [pc_width(WIDTH)-1:0] count
);

    localparam int OUT_W = pc_width(WIDTH);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + OUT_W'(vec[i]);
        end
    end

endmodule

// File: rtl/toggle_activity_counter.sv
// Counts bit toggles and 0->1 rises on a probed bus over a fixed window.
// Define TAC_SATURATE_EN to clamp accumulators at all-ones instead of wrapping.
module toggle_activity_counter
    import tac_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 16,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_count,
    output logic [CNT_W-1:0] res_rise
);

    localparam int PC_W  = pc_width(WIDTH);
    localparam int WIN_W = $clog2(WINDOW + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    tac_state_e       state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] tog_acc_q, tog_acc_d;
    logic [CNT_W-1:0] rise_acc_q, rise_acc_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;

    logic [WIDTH-1:0] tog_vec, rise_vec;
    logic [PC_W-1:0]  tog_pc, rise_pc;

    assign tog_vec  = probe ^ prev_q;
    assign rise_vec = probe & ~prev_q;

    tac_popcount #(.WIDTH(WIDTH)) u_pc_tog (
        .vec   (tog_vec),
        .count (tog_pc)
    );

    tac_popcount #(.WIDTH(WIDTH)) u_pc_rise (
        .vec   (rise_vec),
        .count (rise_pc)
    );

    // One extra carry bit tells us whether the unsigned add overflowed.
    function automatic logic [CNT_W-1:0] acc_add(input logic [CNT_W-1:0] acc,
                                                 input logic [PC_W-1:0]  inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, acc} + (CNT_W + 1)'(inc);
`ifdef TAC_SATURATE_EN
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
`else
        return sum[CNT_W-1:0];
`endif
    endfunction

    always_comb begin
        state_d    = state_q;
        prev_d     = probe;
        tog_acc_d  = tog_acc_q;
        rise_acc_d = rise_acc_q;
        win_cnt_d  = win_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ACCUM;
                    tog_acc_d  = '0;
                    rise_acc_d = '0;
                    win_cnt_d  = '0;
                end
            end
            ACCUM: begin
                tog_acc_d  = acc_add(tog_acc_q, tog_pc);
                rise_acc_d = acc_add(rise_acc_q, rise_pc);
                win_cnt_d  = win_cnt_q + 1'b1;
                if (win_cnt_q == WIN_LAST) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                // A start coinciding with the handshake is dropped on purpose.
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            tog_acc_q  <= '0;
            rise_acc_q <= '0;
            win_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            tog_acc_q  <= tog_acc_d;
            rise_acc_q <= rise_acc_d;
            win_cnt_q  <= win_cnt_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == REPORT);
    assign res_count = res_valid ? tog_acc_q  : '0;
    assign res_rise  = res_valid ? rise_acc_q : '0;

endmodule

// File: tb/tb_toggle_activity_counter.sv
// Scoreboard bench: two counter instances (CNT_W=16 and CNT_W=4) share stimulus;
// expected results come from a full-precision toggle model over recorded windows.
module tb_toggle_activity_counter;

    localparam int WIDTH   = 8;
    localparam int WINDOW  = 16;
    localparam int CNT_W   = 16;
    localparam int CNT_W_B = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               res_ready;
    logic [WIDTH-1:0]   probe;
    logic               busy_a, valid_a, busy_b, valid_b;
    logic [CNT_W-1:0]   cnt_a, rise_a;
    logic [CNT_W_B-1:0] cnt_b, rise_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int start_cyc;
        int cnt_a;
        int rise_a;
        int cnt_b;
        int rise_b;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] win_vals[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    toggle_activity_counter #(.WIDTH(WIDTH), .WINDOW(WINDOW), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .rst(rst), .start(start), .probe(probe), .busy(busy_a),
        .res_valid(valid_a), .res_ready(res_ready), .res_count(cnt_a), .res_rise(rise_a)
    );

    toggle_activity_counter #(.WIDTH(WIDTH), .WINDOW(WINDOW), .CNT_W(CNT_W_B)) dut_b (
        .clk(clk), .rst(rst), .start(start), .probe(probe), .busy(busy_b),
        .res_valid(valid_b), .res_ready(res_ready), .res_count(cnt_b), .res_rise(rise_b)
    );

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reduce an exact count to what a w-bit accumulator should report.
    function automatic int fit(input int full, input int w);
`ifdef TAC_SATURATE_EN
        return (full > (1 << w) - 1) ? (1 << w) - 1 : full;
`else
        return full % (1 << w);
`endif
    endfunction

    task automatic push_expect(input int sc);
        int t;
        int r;
        exp_t e;
        t = 0;
        r = 0;
        for (int i = 1; i < win_vals.size(); i++) begin
            t += $countones(win_vals[i] ^ win_vals[i-1]);
            r += $countones(win_vals[i] & ~win_vals[i-1]);
        end
        e.start_cyc = sc;
        e.cnt_a     = fit(t, CNT_W);
        e.rise_a    = fit(r, CNT_W);
        e.cnt_b     = fit(t, CNT_W_B);
        e.rise_b    = fit(r, CNT_W_B);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: constant 0x5A, 1: 0x00 then alternating 0xFF/0x00,
    // 2: single rise of bit 3, other: random every cycle.
    task automatic run_window(input int mode, input int hold, input bit start_in_rep,
                              input bit start_at_hs);
        logic [WIDTH-1:0] v;
        int sc;
        int flip_at;
        win_vals.delete();
        case (mode)
            0:       v = 8'h5A;
            1:       v = 8'h00;
            default: v = WIDTH'($urandom);
        endcase
        if (mode == 2) v[3] = 1'b0;
        flip_at = $urandom_range(1, WINDOW);
        start = 1'b1;
        probe = v;
        win_vals.push_back(v);
        sc = cyc;
        for (int i = 1; i <= WINDOW; i++) begin
            tick();
            start = 1'b0;
            case (mode)
                0:       v = 8'h5A;
                1:       v = (i % 2 == 1) ? 8'hFF : 8'h00;
                2:       if (i == flip_at) v[3] = 1'b1;
                default: v = WIDTH'($urandom);
            endcase
            probe = v;
            win_vals.push_back(v);
        end
        push_expect(sc);
        res_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            tick();
            probe = WIDTH'($urandom);
            start = start_in_rep && (k == hold / 2);
        end
        tick();
        res_ready = 1'b1;
        start     = start_at_hs;
        tick();
        res_ready = 1'b0;
        start     = 1'b0;
        check("busy_after_handshake", busy_a, 0);
        check("valid_after_handshake", valid_a, 0);
    endtask

    task automatic abort_window();
        start = 1'b1;
        probe = WIDTH'($urandom);
        for (int i = 1; i <= 8; i++) begin
            tick();
            start = 1'b0;
            probe = WIDTH'($urandom);
            if (i == 8) rst = 1'b1;
        end
        tick();
        rst = 1'b0;
        check("busy_after_abort", busy_a, 0);
        check("valid_after_abort", valid_a, 0);
        check("busy_b_after_abort", busy_b, 0);
    endtask

    bit             last_valid = 1'b0;
    bit             last_ready = 1'b0;
    logic [CNT_W-1:0] last_cnt_a = '0, last_rise_a = '0;
    logic [CNT_W_B-1:0] last_cnt_b = '0, last_rise_b = '0;

    always @(negedge clk) begin
        check("valid_b_tracks_a", valid_b, valid_a);
        if (!valid_a) begin
            check("count_zero_when_invalid", cnt_a, 0);
            check("rise_zero_when_invalid", rise_a, 0);
            check("count_b_zero_when_invalid", cnt_b, 0);
            check("rise_b_zero_when_invalid", rise_b, 0);
        end
        if (valid_a && !last_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got res_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                check("valid_latency", cyc - exp_q[0].start_cyc, WINDOW + 1);
            end
        end
        if (last_valid && !last_ready) begin
            check("valid_held", valid_a, 1);
            if (valid_a) begin
                check("count_stable", cnt_a, last_cnt_a);
                check("rise_stable", rise_a, last_rise_a);
                check("count_b_stable", cnt_b, last_cnt_b);
                check("rise_b_stable", rise_b, last_rise_b);
            end
        end
        if (valid_a && res_ready && exp_q.size() > 0) begin
            check("res_count", cnt_a, exp_q[0].cnt_a);
            check("res_rise", rise_a, exp_q[0].rise_a);
            check("res_count_narrow", cnt_b, exp_q[0].cnt_b);
            check("res_rise_narrow", rise_b, exp_q[0].rise_b);
            void'(exp_q.pop_front());
        end
        last_valid  <= valid_a;
        last_ready  <= res_ready;
        last_cnt_a  <= cnt_a;
        last_rise_a <= rise_a;
        last_cnt_b  <= cnt_b;
        last_rise_b <= rise_b;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        res_ready = 1'b0;
        probe     = 8'hC3;
        repeat (3) tick();
        check("reset_busy", busy_a, 0);
        check("reset_valid", valid_a, 0);
        check("reset_count", cnt_a, 0);
        check("reset_rise", rise_a, 0);
        start = 1'b1;
        tick();
        check("reset_beats_start", busy_a, 0);
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) tick();

        run_window(0, 0, 1'b0, 1'b0);
        run_window(1, 5, 1'b1, 1'b0);
        run_window(2, 2, 1'b0, 1'b1);
        tick();
        abort_window();
        repeat (2) tick();
        run_window(3, 1, 1'b0, 1'b0);
        for (int n = 0; n < 8; n++) begin
            run_window($urandom_range(0, 3), $urandom_range(0, 4),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/toggle_activity_counter.md
TOGGLE_ACTIVITY_COUNTER -- requirements
Module: toggle_activity_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the probed bus width in bits (1..64).
REQ-002 The block SHALL have parameter WINDOW, default 16, giving the measurement window length in clock cycles (>=1).
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the accumulator and result width in bits.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit: a one-cycle request to begin a measurement window.
REQ-007 The block SHALL have port probe, input, WIDTH bits: the observed node values, sampled every cycle.
REQ-008 The block SHALL have port busy, output, 1 bit: high when the block is not in IDLE.
REQ-009 The block SHALL have port res_valid, output, 1 bit: result available.
REQ-010 The block SHALL have port res_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port res_count, output, CNT_W bits: total bit toggles in the window.
REQ-012 The block SHALL have port res_rise, output, CNT_W bits: 0->1 transitions in the window.

Function
REQ-013 The FSM SHALL have states IDLE, ACCUM and REPORT.
- IDLE -> ACCUM on start.
- ACCUM -> REPORT after exactly WINDOW ACCUM cycles.
- REPORT -> IDLE on res_valid&&res_ready.
REQ-014 Register prev SHALL load probe every cycle in all states, so the first ACCUM cycle compares against the value sampled in the start cycle.
REQ-015 On start, both accumulators and the window counter SHALL clear to 0.
REQ-016 Each ACCUM cycle SHALL add popcount(probe^prev) to the toggle accumulator and popcount(probe&~prev) to the rise accumulator.
REQ-017 res_valid SHALL assert in the first REPORT cycle (WINDOW+1 cycles after the start cycle), and res_count/res_rise SHALL hold stable while res_valid is high and res_ready is low.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 start and a handshake completing in the same cycle SHALL NOT begin a new window; the block returns to IDLE first.
REQ-020 Accumulator arithmetic SHALL be unsigned; the per-cycle popcount SHALL be $clog2(WIDTH+1) bits, zero-extended to CNT_W.
REQ-021 res_count and res_rise SHALL read 0 whenever res_valid is low.

Reset
REQ-022 rst SHALL force IDLE with busy=0, res_valid=0, res_count=0, res_rise=0, prev=0, and accumulators and window counter at 0.
REQ-023 rst asserted mid-ACCUM or mid-REPORT SHALL discard the partial result, with no res_valid pulse.
REQ-024 rst SHALL take priority over start and res_ready in the same cycle.

Configuration
REQ-025 With TAC_SATURATE_EN defined, each accumulator SHALL clamp at 2^CNT_W-1 once reached and stay there until the next start.
REQ-026 Without TAC_SATURATE_EN, the accumulators SHALL wrap modulo 2^CNT_W.

Structure
REQ-027 Package tac_pkg SHALL hold the FSM state enum (IDLE=0, ACCUM=1, REPORT=2) and the popcount width helper function.
REQ-028 Popcount SHALL be a separate sub-module, tac_popcount (parameter WIDTH, purely combinational), instantiated twice.

Verification
REQ-029 WIDTH=8, WINDOW=16; probe held at 0x5A; start -> res_count=0, res_rise=0, res_valid rising 17 cycles after start.
REQ-030 probe=0x00 in the start cycle, then alternating 0xFF/0x00 starting 0xFF -> res_count=128, res_rise=64.
REQ-031 Single transition of bit 3 from 0 to 1 during the window -> res_count=1, res_rise=1.
REQ-032 res_ready held low 5 cycles in REPORT, and start pulsed during it -> outputs stable, start ignored, IDLE one cycle after res_ready=1.
REQ-033 CNT_W=4 with the REQ-030 stimulus -> res_count=15 with TAC_SATURATE_EN, 0 without (128 mod 16).
REQ-034 rst asserted in the 8th ACCUM cycle -> next cycle busy=0, and res_valid never asserts; a subsequent start yields a clean, full-window result.
